// File: rtl/nmr_seq_pkg.sv
// Shared types and default widths for the NMR pulse sequencer.
package nmr_seq_pkg;

    localparam int N_SEG_DEF    = 8;
    localparam int DUR_W_DEF    = 32;
    localparam int GATE_DLY_DEF = 4;
    localparam int FRQ_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [FRQ_W-1:0]     frq;
        logic [DUR_W_DEF-1:0] dur;
        logic                 gate;
    } seg_t;

endpackage

// File: rtl/nmr_pulse_sequencer_seg_table.sv
// Segment table: N_SEG-entry register file with synchronous write and two
// combinational read ports. Contents survive reset.
module seg_table
    import nmr_seq_pkg::*;
#(
    parameter int N_SEG = N_SEG_DEF,
    parameter int DUR_W = DUR_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(N_SEG)-1:0] wr_addr,
    input  logic [FRQ_W-1:0]         wr_frq,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     wr_gate,
    input  logic [$clog2(N_SEG)-1:0] rd_addr_a,
    output logic [FRQ_W-1:0]         rd_frq_a,
    output logic [DUR_W-1:0]         rd_dur_a,
    output logic                     rd_gate_a,
    input  logic [$clog2(N_SEG)-1:0] rd_addr_b,
    output logic [FRQ_W-1:0]         rd_frq_b,
    output logic [DUR_W-1:0]         rd_dur_b,
    output logic                     rd_gate_b
);

    logic [FRQ_W-1:0] frq_mem  [N_SEG];
    logic [DUR_W-1:0] dur_mem  [N_SEG];
    logic             gate_mem [N_SEG];

    // Table write port
    always_ff @(posedge clk) begin
        if (we) begin
            frq_mem[wr_addr]  <= wr_frq;
            dur_mem[wr_addr]  <= wr_dur;
            gate_mem[wr_addr] <= wr_gate;
        end
    end

    assign rd_frq_a  = frq_mem[rd_addr_a];
    assign rd_dur_a  = dur_mem[rd_addr_a];
    assign rd_gate_a = gate_mem[rd_addr_a];
    assign rd_frq_b  = frq_mem[rd_addr_b];
    assign rd_dur_b  = dur_mem[rd_addr_b];
    assign rd_gate_b = gate_mem[rd_addr_b];

endmodule

// File: rtl/nmr_pulse_sequencer.sv
// NMR pulse sequencer: plays a programmed list of DDS frequency segments,
// optionally repeated, with the transmit gate delayed to match DDS latency.
module nmr_pulse_sequencer
    import nmr_seq_pkg::*;
#(
    parameter int N_SEG    = N_SEG_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int GATE_DLY = GATE_DLY_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(N_SEG)-1:0] cfg_addr,
    input  logic [31:0]              cfg_frq,
    input  logic [DUR_W-1:0]         cfg_dur,
    input  logic                     cfg_gate,
    input  logic [15:0]              repeat_cnt,
    input  logic                     start,
    input  logic                     abort,
    output logic [31:0]              frq,
    output logic                     tx_gate,
    output logic [$clog2(N_SEG)-1:0] seg_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(N_SEG);

    seq_state_e           state_r;
    logic [31:0]          frq_r;
    logic                 gate_r;
    logic [GATE_DLY-1:0]  dly_r;
    logic [AW-1:0]        seg_idx_r;
    logic [DUR_W-1:0]     cnt_r;
    logic [15:0]          pass_r;
    logic                 busy_r;
    logic                 done_r;

    logic [31:0]          head_frq_s;
    logic [DUR_W-1:0]     head_dur_s;
    logic                 head_gate_s;
    logic [31:0]          nxt_frq_s;
    logic [DUR_W-1:0]     nxt_dur_s;
    logic                 nxt_gate_s;
    logic [AW-1:0]        nxt_addr_s;
    logic                 tbl_we_s;
    logic                 last_seg_s;
    logic                 abort_s;

    // Port A always serves the list head (start and wrap); port B the following entry.
    seg_table #(
        .N_SEG (N_SEG),
        .DUR_W (DUR_W)
    ) u_seg_table (
        .clk       (clk),
        .we        (tbl_we_s),
        .wr_addr   (cfg_addr),
        .wr_frq    (cfg_frq),
        .wr_dur    (cfg_dur),
        .wr_gate   (cfg_gate),
        .rd_addr_a ({AW{1'b0}}),
        .rd_frq_a  (head_frq_s),
        .rd_dur_a  (head_dur_s),
        .rd_gate_a (head_gate_s),
        .rd_addr_b (nxt_addr_s),
        .rd_frq_b  (nxt_frq_s),
        .rd_dur_b  (nxt_dur_s),
        .rd_gate_b (nxt_gate_s)
    );

    // Write gating, end-of-list detection and effective abort
    always_comb begin
        tbl_we_s   = cfg_we && (state_r == ST_IDLE);
        nxt_addr_s = seg_idx_r + AW'(1);
        abort_s    = abort && (state_r != ST_IDLE);
        if (seg_idx_r == AW'(N_SEG - 1)) begin
            last_seg_s = 1'b1;
        end else begin
            last_seg_s = (nxt_dur_s == {DUR_W{1'b0}});
        end
    end

    // Sequencer FSM, segment counter and pass counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            frq_r     <= 32'd0;
            gate_r    <= 1'b0;
            seg_idx_r <= {AW{1'b0}};
            cnt_r     <= {DUR_W{1'b0}};
            pass_r    <= 16'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (abort_s) begin
            state_r   <= ST_IDLE;
            frq_r     <= 32'd0;
            gate_r    <= 1'b0;
            seg_idx_r <= {AW{1'b0}};
            cnt_r     <= {DUR_W{1'b0}};
            pass_r    <= 16'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !abort) begin
                        if (head_dur_s != {DUR_W{1'b0}}) begin
                            state_r   <= ST_RUN;
                            busy_r    <= 1'b1;
                            frq_r     <= head_frq_s;
                            gate_r    <= head_gate_s;
                            cnt_r     <= head_dur_s - DUR_W'(1);
                            seg_idx_r <= {AW{1'b0}};
                            pass_r    <= (repeat_cnt == 16'd0) ? 16'd0 : repeat_cnt - 16'd1;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_r != {DUR_W{1'b0}}) begin
                        cnt_r <= cnt_r - DUR_W'(1);
                    end else if (!last_seg_s) begin
                        seg_idx_r <= nxt_addr_s;
                        frq_r     <= nxt_frq_s;
                        gate_r    <= nxt_gate_s;
                        cnt_r     <= nxt_dur_s - DUR_W'(1);
                    end else if (pass_r != 16'd0) begin
                        // Entry 0 cannot change while busy, so its nonzero duration still holds.
                        seg_idx_r <= {AW{1'b0}};
                        frq_r     <= head_frq_s;
                        gate_r    <= head_gate_s;
                        cnt_r     <= head_dur_s - DUR_W'(1);
                        pass_r    <= pass_r - 16'd1;
                    end else begin
                        state_r <= ST_DRAIN;
                        frq_r   <= 32'd0;
                        gate_r  <= 1'b0;
                        cnt_r   <= DUR_W'(GATE_DLY - 1);
                        done_r  <= (GATE_DLY == 1) ? 1'b1 : 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == {DUR_W{1'b0}}) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b0;
                        seg_idx_r <= {AW{1'b0}};
                    end else begin
                        cnt_r  <= cnt_r - DUR_W'(1);
                        done_r <= (cnt_r == DUR_W'(1));
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    frq_r     <= 32'd0;
                    gate_r    <= 1'b0;
                    seg_idx_r <= {AW{1'b0}};
                    cnt_r     <= {DUR_W{1'b0}};
                    pass_r    <= 16'd0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // Gate delay line so tx_gate edges trail frq edges by GATE_DLY clocks
    always_ff @(posedge clk) begin
        if (!rst_n || abort_s) begin
            dly_r <= {GATE_DLY{1'b0}};
        end else begin
            dly_r[0] <= gate_r;
            for (int i = 1; i < GATE_DLY; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    assign frq     = frq_r;
    assign tx_gate = dly_r[GATE_DLY-1];
    assign seg_idx = seg_idx_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
